gf180mcu_fd_sc_mcu7t5v0_rr_arb4: RTL
====================================

Name: gf180mcu_fd_sc_mcu7t5v0_rr_arb4

Overview:
- Four-requester round-robin arbiter/scheduler for one shared resource, e.g. a four-input AND (and4) enable/combine path driven by several agents.
- Grants one requester at a time, with a registered one-hot grant and a break-before-make idle cycle between owners.
- Enforces a bounded hold time so no requester can starve the others.
- Sits beside the combinational cells as the control wrapper for shared gating resources in soft macros built from this library.

Parameters:
- HOLD_MAX, 15: max consecutive grant cycles per owner before forced release; 0 disables the timeout.
- CNT_W, 4: hold-counter width; HOLD_MAX must be < 2**CNT_W (elaboration check).

Ports:
- CLK  input  1  rising-edge clock
- RN  input  1  asynchronous active-low reset
- REQ  input  4  request per agent, level; bit i = agent i
- DONE  input  1  current owner finished; sampled only in GRANT
- GNT  output  4  one-hot grant, registered
- GID  output  2  encoded index of current/last owner, registered
- BUSY  output  1  |GNT
- TMO  output  1  one-cycle pulse on forced (timeout) release
- VDD, VSS  inout  1  present only under USE_POWER_PINS; no functional effect

Interface (already decided): one clock; reset is asynchronous and active-low. Clock is CLK, reset is RN.

Behaviour:
- Reset (RN=0, asynchronous, any state including mid-grant):
  - GNT=0, GID=0, BUSY=0, TMO=0.
  - Pointer PTR=0, counter CNT=0, state IDLE.
  - Release is synchronous to the first CLK rise with RN=1.
- State IDLE: GNT=0.
  - If REQ!=0 at a CLK rise: select the first set bit searching PTR, PTR+1, ... mod 4.
  - Registered result: GNT=onehot(sel), GID=sel, CNT=0, state GRANT.
  - Latency REQ→GNT is one cycle.
- State GRANT, owner g: evaluated at each CLK rise, first match wins:
  1. DONE=1 → release.
  2. REQ[g]=0 → release (requester withdrew).
  3. HOLD_MAX!=0 and CNT==HOLD_MAX-1 → release with TMO=1 for the next cycle.
  4. Otherwise hold GNT, CNT=CNT+1.
- Release:
  - GNT=0, PTR=(g+1) mod 4, CNT=0, state IDLE.
  - GID keeps g.
  - Guarantees at least one cycle of GNT=0 between owners (break-before-make).
- Owner hold length: never more than HOLD_MAX cycles when HOLD_MAX>0.
  - Example, HOLD_MAX=15: GNT high for cycles 0..14, low on cycle 15.
- DONE and timeout in the same cycle: treated as a normal release, TMO=0.
- REQ changes of non-owners during GRANT: ignored; they are sampled only in IDLE.
- DONE while IDLE: ignored.
- Fairness: a requester continuously asserting REQ waits at most 3 owner tenures plus 3 idle cycles.
- Invariants:
  - GNT is always one-hot or zero.
  - GNT bit i is never set unless REQ[i] was high at the granting edge.
- Pointer wrap: PTR is modulo 4 (2-bit natural wrap); after owner 3, PTR=0.
- Counter: CNT saturates, never wraps; it is reset on every new grant.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=1'b0, GRANT=1'b1.
  - Number of requesters, NREQ=4.
  - A function rr_pick(req, ptr) returning a 2-bit index plus a valid flag.
- One natural sub-module: gf180mcu_fd_sc_mcu7t5v0_rr_pick4 (combinational rotating priority encoder).
- The FSM, counter and output registers stay in the top module.

Test Plan:
- Reset mid-grant:
  - Stimulus: grant agent 2 active, drop RN asynchronously between edges.
  - Required: GNT=0, BUSY=0 immediately; after RN=1 and REQ=4'b0100, GNT=4'b0100 one cycle later (PTR back to 0, so search 0,1,2).
- Round-robin rotation:
  - Stimulus: REQ=4'b1111 held, DONE pulsed on the second grant cycle of each tenure.
  - Required: GNT sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
- Timeout:
  - Stimulus: HOLD_MAX=4, REQ=4'b0001 held, DONE=0.
  - Required: GNT=0001 for exactly 4 cycles, then 0000 with TMO=1 for one cycle, then 0001 again.
  - Repeat with HOLD_MAX=0: GNT never drops.
- Withdraw and simultaneous release:
  - Stimulus: agent 1 drops REQ mid-grant.
  - Required: release next edge, TMO=0, PTR=2.
  - Stimulus: DONE=1 on the timeout cycle.
  - Required: release with TMO=0.
- Skip and wrap:
  - Stimulus: PTR=3 (after owner 2), REQ=4'b0011.
  - Required: grant 0 (GID=0), then after release grant 1.
- Random constrained run, 10k cycles:
  - Assertions: GNT one-hot-or-zero; an idle cycle between owners; hold ≤ HOLD_MAX; no grant without request; starvation bound.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0_rr_arb4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter:
// FSM encoding, requester count and the rotating-priority pick function.
package gf180mcu_fd_sc_mcu7t5v0_rr_arb4_pkg;

  localparam int NREQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } pick_t;

  // Scans ptr, ptr+1, ... (mod 4). The loop runs backwards so the
  // candidate closest to ptr is the last one written and therefore wins.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [1:0] ptr);
    pick_t      res;
    logic [1:0] cand;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        res.valid = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0_rr_arb4_pick4.sv
// Combinational rotating-priority encoder: first set request at or after ptr.
module gf180mcu_fd_sc_mcu7t5v0_rr_pick4
  import gf180mcu_fd_sc_mcu7t5v0_rr_arb4_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic            valid,
  output logic [1:0]      idx
);

  pick_t pick;

  always_comb begin
    pick  = rr_pick(req, ptr);
    valid = pick.valid;
    idx   = pick.idx;
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0_rr_arb4.sv
// Four-requester round-robin arbiter with registered one-hot grant,
// break-before-make idle cycle between owners and bounded hold time.
module gf180mcu_fd_sc_mcu7t5v0_rr_arb4
  import gf180mcu_fd_sc_mcu7t5v0_rr_arb4_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
`ifdef USE_POWER_PINS
  inout  wire             VDD,
  inout  wire             VSS,
`endif
  input  logic            CLK,
  input  logic            RN,
  input  logic [NREQ-1:0] REQ,
  input  logic            DONE,
  output logic [NREQ-1:0] GNT,
  output logic [1:0]      GID,
  output logic            BUSY,
  output logic            TMO
);

  if (HOLD_MAX < 0 || HOLD_MAX >= (1 << CNT_W)) begin : g_bad_hold
    $error("HOLD_MAX must be in [0, 2**CNT_W)");
  end

  localparam bit             HOLD_EN   = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(HOLD_MAX - 1) : '0;

  state_t            state_reg, state_next;
  logic [1:0]        ptr_reg, ptr_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic [1:0]        gid_reg, gid_next;
  logic              tmo_reg, tmo_next;
  logic              rel_now;

  logic              pick_valid;
  logic [1:0]        pick_idx;
  logic [NREQ-1:0]   pick_onehot;

  gf180mcu_fd_sc_mcu7t5v0_rr_pick4 u_pick (
    .req   (REQ),
    .ptr   (ptr_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_dec
    assign pick_onehot[gi] = (pick_idx == 2'(gi));
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    gnt_next   = gnt_reg;
    gid_next   = gid_reg;
    tmo_next   = 1'b0;
    rel_now    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          gnt_next   = pick_onehot;
          gid_next   = pick_idx;
          cnt_next   = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        // DONE outranks the timeout, so a coincident DONE never pulses TMO.
        if (DONE || !REQ[gid_reg]) begin
          rel_now = 1'b1;
        end else if (HOLD_EN && cnt_reg == HOLD_LAST) begin
          rel_now  = 1'b1;
          tmo_next = 1'b1;
        end else begin
          cnt_next = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
        end
        if (rel_now) begin
          gnt_next   = '0;
          ptr_next   = gid_reg + 2'd1;
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      gnt_reg   <= '0;
      gid_reg   <= '0;
      tmo_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      gnt_reg   <= gnt_next;
      gid_reg   <= gid_next;
      tmo_reg   <= tmo_next;
    end
  end

  assign GNT  = gnt_reg;
  assign GID  = gid_reg;
  assign BUSY = |gnt_reg;
  assign TMO  = tmo_reg;

endmodule
